// File: rtl/mul8_err_monitor.sv
// rtl/mul8_err_monitor.sv - error statistics (sum |err|, worst error, error count) for an 8x8 approximate multiplier
module mul8_err_monitor #(
    parameter int N_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_a,
    input  logic [7:0]            in_b,
    input  logic [15:0]           in_o,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [15+N_LOG2:0]    sum_abs_err,
    output logic [15:0]           max_err,
    output logic [7:0]            max_a,
    output logic [7:0]            max_b,
    output logic [N_LOG2:0]       err_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    localparam logic [N_LOG2:0] LAST = (N_LOG2 + 1)'((1 << N_LOG2) - 1);

    state_t            state;
    logic [N_LOG2:0]   cnt;
    logic              s1_valid;
    logic [7:0]        s1_a;
    logic [7:0]        s1_b;
    logic [15:0]       s1_o;

    logic              accept;
    logic [15:0]       exact;
    logic [16:0]       diff;
    logic [16:0]       neg_diff;
    logic [15:0]       abs_err;

    assign in_ready  = (state == RUN);
    assign res_valid = (state == REPORT);
    assign busy      = (state == RUN) || (state == DRAIN);
    assign accept    = in_valid && in_ready;

    // Exact product minus the approximate one, widened so overestimates come out negative
    assign exact    = {8'd0, s1_a} * {8'd0, s1_b};
    assign diff     = {1'b0, exact} - {1'b0, s1_o};
    assign neg_diff = 17'd0 - diff;
    assign abs_err  = diff[16] ? neg_diff[15:0] : diff[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_o        <= '0;
            sum_abs_err <= '0;
            max_err     <= '0;
            max_a       <= '0;
            max_b       <= '0;
            err_count   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a <= in_a;
                s1_b <= in_b;
                s1_o <= in_o;
            end

            if (s1_valid) begin
                sum_abs_err <= sum_abs_err + (16 + N_LOG2)'(abs_err);
                err_count   <= err_count + (N_LOG2 + 1)'(abs_err != 16'd0);
                // Strict compare keeps the earliest sample on ties
                if (abs_err > max_err) begin
                    max_err <= abs_err;
                    max_a   <= s1_a;
                    max_b   <= s1_b;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt         <= '0;
                        s1_valid    <= 1'b0;
                        sum_abs_err <= '0;
                        max_err     <= '0;
                        max_a       <= '0;
                        max_b       <= '0;
                        err_count   <= '0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    state <= REPORT;
                end
                REPORT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul8_err_monitor.sv
// tb/tb_mul8_err_monitor.sv - randomized self-checking bench for mul8_err_monitor
module tb_mul8_err_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [15:0] in_o = '0;
    logic        in_valid = 1'b0;
    logic [2:0]  start_v = '0;
    logic [2:0]  res_ready_v = '0;
    logic [2:0]  busy_v, in_ready_v, res_valid_v;
    logic [17:0] sum0;
    logic [16:0] sum1;
    logic [23:0] sum2;
    logic [2:0][15:0] maxe;
    logic [2:0][7:0]  ma, mb;
    logic [2:0]  cnt0;
    logic [1:0]  cnt1;
    logic [8:0]  cnt2;

    // Instance 0: 4-sample window, 1: 2-sample window, 2: 256-sample window
    mul8_err_monitor #(.N_LOG2(2)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]),
        .in_valid(in_valid), .in_ready(in_ready_v[0]), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid_v[0]), .res_ready(res_ready_v[0]), .sum_abs_err(sum0),
        .max_err(maxe[0]), .max_a(ma[0]), .max_b(mb[0]), .err_count(cnt0));
    mul8_err_monitor #(.N_LOG2(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]),
        .in_valid(in_valid), .in_ready(in_ready_v[1]), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid_v[1]), .res_ready(res_ready_v[1]), .sum_abs_err(sum1),
        .max_err(maxe[1]), .max_a(ma[1]), .max_b(mb[1]), .err_count(cnt1));
    mul8_err_monitor #(.N_LOG2(8)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]),
        .in_valid(in_valid), .in_ready(in_ready_v[2]), .in_a(in_a), .in_b(in_b), .in_o(in_o),
        .res_valid(res_valid_v[2]), .res_ready(res_ready_v[2]), .sum_abs_err(sum2),
        .max_err(maxe[2]), .max_a(ma[2]), .max_b(mb[2]), .err_count(cnt2));

    logic [1:0]  sel = '0;
    logic        busy, in_ready, res_valid;
    logic [31:0] o_sum, o_max, o_ma, o_mb, o_cnt;

    always_comb begin
        busy      = busy_v[sel];
        in_ready  = in_ready_v[sel];
        res_valid = res_valid_v[sel];
        o_max     = 32'(maxe[sel]);
        o_ma      = 32'(ma[sel]);
        o_mb      = 32'(mb[sel]);
        o_sum     = (sel == 2'd0) ? 32'(sum0) : (sel == 2'd1) ? 32'(sum1) : 32'(sum2);
        o_cnt     = (sel == 2'd0) ? 32'(cnt0) : (sel == 2'd1) ? 32'(cnt1) : 32'(cnt2);
    end

    int n_cmp = 0;
    int n_bad = 0;
    int qa[$], qb[$], qo[$];
    int exp_sum, exp_max, exp_ma, exp_mb, exp_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        exp_sum = 0; exp_max = 0; exp_ma = 0; exp_mb = 0; exp_cnt = 0;
        foreach (qa[i]) begin
            int e;
            e = qa[i] * qb[i] - qo[i];
            if (e < 0) e = -e;
            exp_sum += e;
            if (e != 0) exp_cnt++;
            if (e > exp_max) begin
                exp_max = e; exp_ma = qa[i]; exp_mb = qb[i];
            end
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_sum"}, o_sum, 32'(exp_sum));
        check({tag, "_max"}, o_max, 32'(exp_max));
        check({tag, "_max_a"}, o_ma, 32'(exp_ma));
        check({tag, "_max_b"}, o_mb, 32'(exp_mb));
        check({tag, "_cnt"}, o_cnt, 32'(exp_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int s);
        start_v[s] = 1'b1;
        tick();
        start_v[s] = 1'b0;
    endtask

    task automatic feed_one(input int a, input int b, input int o);
        in_a = 8'(a); in_b = 8'(b); in_o = 16'(o); in_valid = 1'b1;
        check("in_ready_run", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // gaps < 0: random 0..2 idle cycles before each sample; otherwise fixed count
    task automatic run_window(input int s, input string tag, input int gaps,
                              input bit poke_start, input int hold);
        sel = 2'(s);
        model();
        pulse_start(s);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        foreach (qa[i]) begin
            int g;
            g = (gaps < 0) ? int'($urandom_range(2)) : gaps;
            if (i == 0) g = 0;
            repeat (g) begin
                in_valid = 1'b0;
                in_a = 8'($urandom); in_b = 8'($urandom); in_o = 16'($urandom);
                if (poke_start) start_v[s] = 1'b1;
                tick();
                start_v[s] = 1'b0;
            end
            feed_one(qa[i], qb[i], qo[i]);
        end
        // Junk sample offered during DRAIN must not be captured
        in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255; in_o = 16'd0;
        check({tag, "_drain_rv"}, 32'(res_valid), 32'd0);
        check({tag, "_drain_rdy"}, 32'(in_ready), 32'd0);
        tick();
        check({tag, "_rv"}, 32'(res_valid), 32'd1);
        check({tag, "_busy_rep"}, 32'(busy), 32'd0);
        check({tag, "_rdy_rep"}, 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        check_results(tag);
        for (int k = 0; k < hold; k++) begin
            tick();
            check({tag, "_hold_rv"}, 32'(res_valid), 32'd1);
            check_results({tag, "_hold"});
        end
        res_ready_v[s] = 1'b1;
        tick();
        res_ready_v[s] = 1'b0;
        check({tag, "_rv_drop"}, 32'(res_valid), 32'd0);
        check({tag, "_kept_sum"}, o_sum, 32'(exp_sum));
    endtask

    task automatic push(input int a, input int b, input int o);
        qa.push_back(a); qb.push_back(b); qo.push_back(o);
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qo.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #0;
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rdy", 32'(in_ready), 32'd0);
            check("rst_rv", 32'(res_valid), 32'd0);
            check("rst_sum", o_sum, 32'd0);
            check("rst_cnt", o_cnt, 32'd0);
        end
        rst = 1'b0;
        tick();

        clear_q();
        push(3, 5, 15); push(10, 10, 90); push(200, 2, 944); push(7, 7, 49);
        run_window(0, "basic", 0, 1'b0, 0);

        clear_q();
        push(1, 1, 3); push(2, 2, 2); push(0, 9, 2); push(1, 1, 1);
        run_window(0, "tie", 0, 1'b0, 0);

        clear_q();
        push(255, 255, 0); push(255, 255, 0);
        run_window(1, "worst", 0, 1'b0, 5);

        clear_q();
        push(12, 13, 150); push(40, 3, 100); push(9, 9, 81); push(250, 250, 60000);
        run_window(0, "gaps", 2, 1'b1, 0);

        // Asynchronous reset after two of four samples
        clear_q();
        sel = 2'd0;
        pulse_start(0);
        feed_one(100, 100, 0);
        feed_one(50, 50, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rdy", 32'(in_ready), 32'd0);
        check("arst_rv", 32'(res_valid), 32'd0);
        check("arst_sum", o_sum, 32'd0);
        check("arst_max", o_max, 32'd0);
        check("arst_ma", o_ma, 32'd0);
        check("arst_mb", o_mb, 32'd0);
        check("arst_cnt", o_cnt, 32'd0);
        #2 rst = 1'b0;
        in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200; in_o = 16'd0;
        tick();
        tick();
        in_valid = 1'b0;
        check("post_rst_idle", 32'(busy), 32'd0);
        check("post_rst_sum", o_sum, 32'd0);
        push(6, 7, 40); push(8, 8, 64); push(11, 11, 130); push(2, 3, 6);
        run_window(0, "fresh", 0, 1'b0, 0);

        for (int w = 0; w < 6; w++) begin
            clear_q();
            for (int i = 0; i < 4; i++) begin
                int a, b, o;
                a = int'($urandom_range(255));
                b = int'($urandom_range(255));
                o = a * b;
                if ($urandom_range(3) != 0) o = o + int'($urandom_range(600)) - 300;
                if (o < 0) o = 0;
                if (o > 65535) o = 65535;
                push(a, b, o);
            end
            run_window(0, $sformatf("rand%0d", w), -1, 1'b1, 0);
        end

        clear_q();
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = int'($urandom_range(255));
            b = int'($urandom_range(255));
            push(a, b, a * b);
        end
        run_window(2, "exact256", -1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
